// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, reset defaults, fetch FSM encoding
// and the opcode constants shared between fetch and main_decoder.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned STATE_W = 3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [STATE_W-1:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_VALID = 3'd3,
        FETCH_FAULT = 3'd4
    } fetch_state_e;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus; fetch unit is master, memory is slave.
interface instr_fetch_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) ();
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_logic.sv
// Sequential-PC adder, redirect mux and alignment check for the fetch unit.
module pc_next_logic #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_plus4_c,
    output logic [XLEN-1:0] pc_next_c,
    output logic            misaligned_c
);
    localparam int unsigned ALIGN_W = 2;

    // Adder wraps modulo 2^XLEN by construction.
    always_comb begin
        pc_plus4_c   = pc + XLEN'(4);
        pc_next_c    = pc_src ? pc_target : pc_plus4_c;
        misaligned_c = |pc_next_c[ALIGN_W-1:0];
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: owns the PC, presents Instr/PC
// to decode, follows resolved redirects and counts retired instructions.
module instr_fetch #(
    parameter int unsigned     XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_if.master         imem,
    output logic [31:0]           Instr,
    output logic [XLEN-1:0]       PC,
    output logic [XLEN-1:0]       PCPlus4,
    output logic                  instr_valid,
    input  logic                  dec_ready,
    input  logic                  PCSrc,
    input  logic [XLEN-1:0]       PCTarget,
    output logic                  fetch_fault,
    output logic [31:0]           instret
);
    import riscv_pkg::*;

    localparam logic [STATE_W-1:0] S_IDLE  = FETCH_IDLE;
    localparam logic [STATE_W-1:0] S_REQ   = FETCH_REQ;
    localparam logic [STATE_W-1:0] S_WAIT  = FETCH_WAIT;
    localparam logic [STATE_W-1:0] S_VALID = FETCH_VALID;
    localparam logic [STATE_W-1:0] S_FAULT = FETCH_FAULT;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_d;
    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    fetch_pc_d;
    logic [ILEN-1:0]    instr_d;
    logic [XLEN-1:0]    pc_d;
    logic [31:0]        instret_d;
    logic               req;
    logic [XLEN-1:0]    pc_next_c;
    logic               misaligned_c;

    pc_next_logic #(.XLEN(XLEN)) u_pc_next (
        .pc           (PC),
        .pc_src       (PCSrc),
        .pc_target    (PCTarget),
        .pc_plus4_c   (PCPlus4),
        .pc_next_c    (pc_next_c),
        .misaligned_c (misaligned_c)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc;

    // Next-state and datapath update; redirect inputs only matter on accept.
    always_comb begin
        state_d    = state;
        fetch_pc_d = fetch_pc;
        instr_d    = Instr;
        pc_d       = PC;
        instret_d  = instret;
        case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem.imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    instr_d = imem.imem_rdata;
                    pc_d    = fetch_pc;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (dec_ready) begin
                    instret_d = instret + 32'd1;
                    if (misaligned_c) begin
                        state_d = S_FAULT;
                    end else begin
                        fetch_pc_d = pc_next_c;
                        state_d    = S_REQ;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            Instr       <= NOP_INSTR;
            PC          <= RESET_PC;
            instret     <= 32'd0;
            req         <= 1'b0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_d;
            fetch_pc    <= fetch_pc_d;
            Instr       <= instr_d;
            PC          <= pc_d;
            instret     <= instret_d;
            req         <= (state_d == S_REQ);
            instr_valid <= (state_d == S_VALID);
            fetch_fault <= (state_d == S_FAULT);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus queues expected fetches
// and accepts, monitors pop and compare as the DUT presents them.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        dec_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        fetch_fault;
    logic [31:0] instret;

    instr_fetch_if #(.XLEN(32)) ifc ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (ifc.master),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .fetch_fault (fetch_fault),
        .instret     (instret)
    );

    // Second instance exercising a top-of-memory reset PC.
    logic        rst2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] pcplus4_2;
    logic        instr_valid2;
    logic        dec_ready2;
    logic        pcsrc2;
    logic [31:0] pctarget2;
    logic        fetch_fault2;
    logic [31:0] instret2;

    instr_fetch_if #(.XLEN(32)) ifc2 ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .imem        (ifc2.master),
        .Instr       (instr2),
        .PC          (pc2),
        .PCPlus4     (pcplus4_2),
        .instr_valid (instr_valid2),
        .dec_ready   (dec_ready2),
        .PCSrc       (pcsrc2),
        .PCTarget    (pctarget2),
        .fetch_fault (fetch_fault2),
        .instret     (instret2)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    logic        gnt_en;
    logic        stray;
    logic [31:0] exp_fetch[$];
    logic [31:0] exp_acc[$];
    logic [31:0] exp2[$];
    logic [31:0] exp_instret;
    logic        ir_pending;
    logic        seen2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return {16'hC0DE, a[8:0], 7'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    // Memory model for dut: grants when enabled, returns data one cycle later.
    initial begin
        logic        pend;
        logic [31:0] paddr;
        pend = 1'b0;
        paddr = '0;
        ifc.imem_gnt = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata = '0;
        forever begin
            @(negedge clk);
            #3;
            ifc.imem_rvalid = (pend || stray) && !rst;
            ifc.imem_rdata  = pend ? word(paddr) : (stray ? 32'hBADB_AD13 : 32'h0);
            if (rst) pend = 1'b0;
            pend = 1'b0;
            ifc.imem_gnt = ifc.imem_req && gnt_en && !rst;
            if (ifc.imem_gnt) begin
                pend  = 1'b1;
                paddr = ifc.imem_addr;
            end
        end
    end

    // Monitor: fetch addresses, accepted instructions and retire count.
    initial begin
        logic [31:0] e;
        exp_instret = '0;
        ir_pending = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (ir_pending) begin
                chk("instret", instret, exp_instret);
                ir_pending = 1'b0;
            end
            if (rst) begin
                exp_instret = '0;
            end else if (instr_valid && dec_ready) begin
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept: unexpected accept of PC %08h", PC);
                end else begin
                    e = exp_acc.pop_front();
                    chk("acc_pc", PC, e);
                    chk("acc_instr", Instr, word(e));
                    chk("acc_pcplus4", PCPlus4, e + 32'd4);
                end
                exp_instret = exp_instret + 32'd1;
                ir_pending = 1'b1;
            end
            if (!rst && ifc.imem_req && ifc.imem_gnt) begin
                if (exp_fetch.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fetch: unexpected fetch of %08h", ifc.imem_addr);
                end else begin
                    e = exp_fetch.pop_front();
                    chk("fetch_addr", ifc.imem_addr, e);
                end
            end
        end
    end

    // Memory model and monitor for dut2 (always grants, always accepts).
    initial begin
        logic        pend;
        logic [31:0] paddr;
        logic [31:0] e;
        pend = 1'b0;
        paddr = '0;
        seen2 = 1'b0;
        ifc2.imem_gnt = 1'b0;
        ifc2.imem_rvalid = 1'b0;
        ifc2.imem_rdata = '0;
        forever begin
            @(negedge clk);
            #3;
            ifc2.imem_rvalid = pend && !rst2;
            ifc2.imem_rdata  = pend ? word(paddr) : 32'h0;
            pend = 1'b0;
            ifc2.imem_gnt = ifc2.imem_req && !rst2;
            if (ifc2.imem_gnt) begin
                pend  = 1'b1;
                paddr = ifc2.imem_addr;
            end
            #1;
            if (!rst2 && ifc2.imem_req && ifc2.imem_gnt && exp2.size() > 0) begin
                e = exp2.pop_front();
                chk("wrap_fetch_addr", ifc2.imem_addr, e);
            end
            if (!rst2 && instr_valid2 && !seen2) begin
                chk("wrap_pc", pc2, 32'hFFFF_FFFC);
                chk("wrap_pcplus4", pcplus4_2, 32'h0000_0000);
                seen2 = 1'b1;
            end
        end
    end

    initial begin
        rst2 = 1'b1;
        dec_ready2 = 1'b1;
        pcsrc2 = 1'b0;
        pctarget2 = '0;
        exp2.push_back(32'hFFFF_FFFC);
        exp2.push_back(32'h0000_0000);
        exp2.push_back(32'h0000_0004);
        repeat (2) tick();
        chk("wrap_rst_pcplus4", pcplus4_2, 32'h0000_0000);
        rst2 = 1'b0;
    end

    // Directed stimulus.
    initial begin
        int vcyc[3];
        rst = 1'b1;
        gnt_en = 1'b1;
        stray = 1'b0;
        dec_ready = 1'b1;
        PCSrc = 1'b0;
        PCTarget = '0;
        repeat (2) tick();

        chk("rst_req", 32'(ifc.imem_req), 32'd0);
        chk("rst_addr", ifc.imem_addr, 32'h0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcplus4", PCPlus4, 32'h4);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_instret", instret, 32'd0);

        // Sequential fetch 0,4,8; the accept at 8 redirects to 0x40.
        exp_fetch.push_back(32'h00); exp_fetch.push_back(32'h04);
        exp_fetch.push_back(32'h08); exp_fetch.push_back(32'h40);
        exp_acc.push_back(32'h00); exp_acc.push_back(32'h04); exp_acc.push_back(32'h08);
        rst = 1'b0;
        tick();
        chk("first_req_cycle", 32'(ifc.imem_req), 32'd1);
        chk("first_req_addr", ifc.imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            wait_valid("valid_seq");
            vcyc[i] = cycle;
            if (i == 2) begin
                PCSrc = 1'b1;
                PCTarget = 32'h40;
                gnt_en = 1'b0;
            end
            tick();
            PCSrc = 1'b0;
        end
        chk("cadence_1", 32'(vcyc[1] - vcyc[0]), 32'd3);
        chk("cadence_2", 32'(vcyc[2] - vcyc[1]), 32'd3);

        // Grant withheld for 5 cycles, then decode stalls for 4 cycles.
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 32'(ifc.imem_req), 32'd1);
            chk("hold_addr", ifc.imem_addr, 32'h40);
            tick();
        end
        gnt_en = 1'b1;
        dec_ready = 1'b0;
        PCSrc = 1'b1;
        PCTarget = 32'h80;
        wait_valid("valid_stall");
        for (int i = 0; i < 4; i++) begin
            stray = (i == 1);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", PC, 32'h40);
            chk("stall_instr", Instr, word(32'h40));
            chk("stall_pcplus4", PCPlus4, 32'h44);
            chk("stall_instret", instret, 32'd3);
            tick();
        end
        stray = 1'b0;
        chk("stall_instr_after_stray", Instr, word(32'h40));
        exp_acc.push_back(32'h40);
        exp_fetch.push_back(32'h44);
        exp_fetch.push_back(32'h00);
        PCSrc = 1'b0;
        dec_ready = 1'b1;

        // Reset while waiting for read data of 0x44.
        tick();
        tick();
        chk("wait_req_low", 32'(ifc.imem_req), 32'd0);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_instret", instret, 32'd0);
        chk("midrst_req", 32'(ifc.imem_req), 32'd0);
        chk("midrst_pc", PC, 32'h0);
        rst = 1'b0;
        tick();
        chk("restart_req", 32'(ifc.imem_req), 32'd1);
        chk("restart_addr", ifc.imem_addr, 32'h0);

        // Misaligned redirect faults and stops fetching.
        exp_acc.push_back(32'h00);
        wait_valid("valid_fault");
        PCSrc = 1'b1;
        PCTarget = 32'h42;
        tick();
        PCSrc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stray = (i == 3);
            chk("fault_flag", 32'(fetch_fault), 32'd1);
            chk("fault_req", 32'(ifc.imem_req), 32'd0);
            chk("fault_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        stray = 1'b0;
        chk("fault_instret", instret, 32'd1);

        // Reset clears the fault; retire counter wraps from all-ones.
        exp_fetch.push_back(32'h00);
        exp_fetch.push_back(32'h04);
        rst = 1'b1;
        tick();
        tick();
        chk("clr_fault", 32'(fetch_fault), 32'd0);
        chk("clr_instret", instret, 32'd0);
        chk("clr_addr", ifc.imem_addr, 32'h0);
        chk("clr_instr", Instr, 32'h0000_0013);
        rst = 1'b0;
        dec_ready = 1'b0;
        wait_valid("valid_wrap");
        chk("wrap_pc0", PC, 32'h0);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        exp_instret = 32'hFFFF_FFFF;
        exp_acc.push_back(32'h00);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("instret_wrap", instret, 32'd0);
        wait_valid("valid_last");
        chk("last_pc", PC, 32'h4);
        repeat (3) tick();

        chk("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
        chk("accept_queue_empty", 32'(exp_acc.size()), 32'd0);
        chk("wrap_queue_empty", 32'(exp2.size()), 32'd0);
        chk("wrap_seen", 32'(seen2), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
